jk_to_t: RTL and testbench

JK_TO_T -- requirements
Module: jk_to_t

---
 rtl/jk_to_t_pkg.sv | 30 +++
 rtl/jk_ff.sv | 54 +++++
 rtl/jk_to_t.sv | 89 ++++++++
 tb/tb_jk_to_t.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_to_t_pkg.sv
// ---------------------------------------------------------------------------
// jk_to_t_pkg
// Shared types and constants for the JK-based T flip-flop.
//   jk_cmd_e    : decoded JK action (hold / reset / set / toggle)
//   Q_RST_VAL   : value Q takes on reset and on clear
//   CNT_W_DEF   : default width of the optional toggle counter
//   jk_decode() : maps a J/K input pair onto a jk_cmd_e
// ---------------------------------------------------------------------------
package jk_to_t_pkg;

   typedef enum logic [1:0] {
      JK_HOLD   = 2'b00,
      JK_RESET  = 2'b01,
      JK_SET    = 2'b10,
      JK_TOGGLE = 2'b11
   } jk_cmd_e;

   localparam logic Q_RST_VAL = 1'b0;
   localparam int   CNT_W_DEF = 8;

   function automatic jk_cmd_e jk_decode(input logic j, input logic k);
      case ({j, k})
         2'b00:   return JK_HOLD;
         2'b01:   return JK_RESET;
         2'b10:   return JK_SET;
         default: return JK_TOGGLE;
      endcase
   endfunction

endpackage

// File: rtl/jk_ff.sv
// ---------------------------------------------------------------------------
// jk_ff
// Edge-triggered JK flip-flop with synchronous reset, clear and preset.
// Priority at each rising edge: rst, clr, pre, then the J/K action.
// Ports:
//   clk  : clock, rising edge active
//   rst  : synchronous reset, active-high (Q <= Q_RST_VAL)
//   clr  : synchronous clear, active-high (Q <= 0)
//   pre  : synchronous preset, active-high (Q <= 1)
//   J, K : JK inputs (00 hold, 01 reset, 10 set, 11 toggle)
//   Q    : registered state
//   Qbar : complement of Q, derived from the same register
// ---------------------------------------------------------------------------
module jk_ff
   import jk_to_t_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic pre,
   input  logic J,
   input  logic K,
   output logic Q,
   output logic Qbar
);

   logic    q_r;
   jk_cmd_e cmd;

   assign cmd = jk_decode(J, K);

   always_ff @(posedge clk) begin
      if (rst) begin
         q_r <= Q_RST_VAL;
      end else if (clr) begin
         q_r <= 1'b0;
      end else if (pre) begin
         q_r <= 1'b1;
      end else begin
         case (cmd)
            JK_HOLD:   q_r <= q_r;
            JK_RESET:  q_r <= 1'b0;
            JK_SET:    q_r <= 1'b1;
            JK_TOGGLE: q_r <= ~q_r;
            default:   q_r <= q_r;
         endcase
      end
   end

   // Both outputs come from one register, so they can never agree.
   assign Q    = q_r;
   assign Qbar = ~q_r;

endmodule

// File: rtl/jk_to_t.sv
// ---------------------------------------------------------------------------
// jk_to_t
// T flip-flop built from a JK core with J = K = T, plus active-low
// synchronous clear/preset. Optional statistics (toggle counter and
// one-cycle Q edge pulses) are built when JK_TO_T_STATS_EN is defined.
// Parameters:
//   CNT_W      : width of toggle_cnt
// Ports:
//   clk        : clock, rising edge active
//   rst        : synchronous reset, active-high, highest priority
//   clr_bar    : synchronous clear, active-low, beats pre_bar
//   pre_bar    : synchronous preset, active-low
//   T          : toggle request
//   Q, Qbar    : flip-flop state and its complement
//   toggle_cnt : (JK_TO_T_STATS_EN) count of JK toggles, wraps; cleared by
//                rst or clr_bar = 0
//   q_rise     : (JK_TO_T_STATS_EN) high the cycle after Q went 0 -> 1
//   q_fall     : (JK_TO_T_STATS_EN) high the cycle after Q went 1 -> 0
// ---------------------------------------------------------------------------
module jk_to_t
   import jk_to_t_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_bar,
   input  logic             pre_bar,
   input  logic             T,
   output logic             Q,
   output logic             Qbar
`ifdef JK_TO_T_STATS_EN
   ,
   output logic [CNT_W-1:0] toggle_cnt,
   output logic             q_rise,
   output logic             q_fall
`endif
);

   logic clr;
   logic pre;

   // Clear outranks preset: when both are low, preset is masked off.
   assign clr = ~clr_bar;
   assign pre = ~pre_bar & clr_bar;

   jk_ff u_jk_ff (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .pre  (pre),
      .J    (T),
      .K    (T),
      .Q    (Q),
      .Qbar (Qbar)
   );

`ifdef JK_TO_T_STATS_EN
   logic             toggle_evt;
   logic [CNT_W-1:0] cnt_r;
   logic             q_prev;

   // A toggle counts only when the JK action actually reaches the core.
   assign toggle_evt = ~rst & clr_bar & pre_bar & T;

   always_ff @(posedge clk) begin
      if (rst || !clr_bar) begin
         cnt_r <= '0;
      end else if (toggle_evt) begin
         cnt_r <= cnt_r + 1'b1;
      end
   end

   // q_prev lags Q by one edge; forcing it on reset suppresses a spurious
   // q_fall when reset drops Q from 1 to 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_prev <= Q_RST_VAL;
      end else begin
         q_prev <= Q;
      end
   end

   assign toggle_cnt = cnt_r;
   assign q_rise     = Q & ~q_prev;
   assign q_fall     = ~Q & q_prev;
`endif

endmodule

// File: tb/tb_jk_to_t.sv
module tb_jk_to_t;

   localparam int CNT_W = 8;
`ifdef JK_TO_T_STATS_EN
   localparam int OBS_W = CNT_W + 4;
`else
   localparam int OBS_W = 2;
`endif

   typedef logic [OBS_W-1:0] obs_t;

   logic clk = 1'b0;
   logic rst, clr_bar, pre_bar, T;
   logic Q, Qbar;
`ifdef JK_TO_T_STATS_EN
   logic [CNT_W-1:0] toggle_cnt;
   logic             q_rise, q_fall;
`endif

   always #5 clk = ~clk;

   jk_to_t #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .clr_bar    (clr_bar),
      .pre_bar    (pre_bar),
      .T          (T),
      .Q          (Q),
      .Qbar       (Qbar)
`ifdef JK_TO_T_STATS_EN
      ,
      .toggle_cnt (toggle_cnt),
      .q_rise     (q_rise),
      .q_fall     (q_fall)
`endif
   );

   obs_t             sb[$];
   logic             m_q;
   logic [CNT_W-1:0] m_cnt;
   int               checks = 0;
   int               errors = 0;
   logic             armed  = 1'b0;

   function automatic obs_t observe();
`ifdef JK_TO_T_STATS_EN
      return {Q, Qbar, toggle_cnt, q_rise, q_fall};
`else
      return {Q, Qbar};
`endif
   endfunction

   // Drive one edge's worth of inputs, push the reference result, wait the edge.
   task automatic apply(input logic r, input logic c, input logic p, input logic t);
      logic             nq;
      logic [CNT_W-1:0] nc;
      obs_t             e;
      rst = r; clr_bar = c; pre_bar = p; T = t;
      nc = m_cnt;
      if (r)       begin nq = 1'b0; nc = '0; end
      else if (!c) begin nq = 1'b0; nc = '0; end
      else if (!p) nq = 1'b1;
      else if (t)  begin nq = ~m_q; nc = m_cnt + 1'b1; end
      else         nq = m_q;
`ifdef JK_TO_T_STATS_EN
      e = {nq, ~nq, nc, ~r & nq & ~m_q, ~r & ~nq & m_q};
`else
      e = {nq, ~nq};
`endif
      m_q   = nq;
      m_cnt = nc;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Qbar must be the complement of Q throughout, sampled mid-cycle.
   always @(negedge clk) begin
      if (armed) begin
         checks++;
         if (Qbar !== ~Q) begin
            errors++;
            $display("FAIL qbar_invariant: Q=%b Qbar=%b, required Qbar=%b", Q, Qbar, ~Q);
         end
      end
   end

   task automatic test_reset();
      obs_t e;
      for (int i = 0; i < 3; i++) begin
         apply(i < 2, 1'b1, 1'b1, 1'b0);
         e = sb.pop_front();
         checks++;
         if (observe() !== e) begin
            errors++;
            $display("FAIL reset[%0d]: got %b, required %b", i, observe(), e);
         end
      end
      armed = 1'b1;
      checks++;
      if ({Q, Qbar} !== 2'b01) begin
         errors++;
         $display("FAIL reset_q: got %b, required 01", {Q, Qbar});
      end
   endtask

   task automatic test_clear_toggle();
      obs_t e;
      int   rises = 0;
      for (int i = 0; i < 6; i++) begin
         if (i < 2) apply(1'b0, 1'b0, 1'b1, 1'b0);
         else       apply(1'b0, 1'b1, 1'b1, 1'b1);
         e = sb.pop_front();
         checks++;
         if (observe() !== e) begin
            errors++;
            $display("FAIL clear_toggle[%0d]: got %b, required %b", i, observe(), e);
         end
         if (i >= 2) begin
            checks++;
            if (Q !== ((i % 2) == 0)) begin
               errors++;
               $display("FAIL clear_toggle_q[%0d]: got %b, required %b", i, Q, (i % 2) == 0);
            end
         end
`ifdef JK_TO_T_STATS_EN
         if (q_rise === 1'b1) rises++;
`endif
      end
`ifdef JK_TO_T_STATS_EN
      checks++;
      if (toggle_cnt !== 8'd4 || rises != 2) begin
         errors++;
         $display("FAIL clear_toggle_stats: cnt=%0d rises=%0d, required cnt=4 rises=2", toggle_cnt, rises);
      end
`endif
   endtask

   task automatic test_hold();
      obs_t e;
      for (int i = 0; i < 4; i++) begin
         apply(1'b0, 1'b1, 1'b1, i == 0);
         e = sb.pop_front();
         checks++;
         if (observe() !== e) begin
            errors++;
            $display("FAIL hold[%0d]: got %b, required %b", i, observe(), e);
         end
      end
      checks++;
      if (Q !== 1'b1) begin
         errors++;
         $display("FAIL hold_q: got %b, required 1", Q);
      end
`ifdef JK_TO_T_STATS_EN
      checks++;
      if (toggle_cnt !== 8'd5) begin
         errors++;
         $display("FAIL hold_cnt: got %0d, required 5", toggle_cnt);
      end
`endif
   endtask

   task automatic test_preset();
      obs_t e;
      int   rises = 0;
      // clear, toggle twice (Q back to 0, count 2), preset with T=1, hold
      for (int i = 0; i < 5; i++) begin
         case (i)
            0:       apply(1'b0, 1'b0, 1'b1, 1'b0);
            1, 2:    apply(1'b0, 1'b1, 1'b1, 1'b1);
            3:       apply(1'b0, 1'b1, 1'b0, 1'b1);
            default: apply(1'b0, 1'b1, 1'b1, 1'b0);
         endcase
         e = sb.pop_front();
         checks++;
         if (observe() !== e) begin
            errors++;
            $display("FAIL preset[%0d]: got %b, required %b", i, observe(), e);
         end
         if (i == 3) begin
            checks++;
            if ({Q, Qbar} !== 2'b10) begin
               errors++;
               $display("FAIL preset_q: got %b, required 10", {Q, Qbar});
            end
         end
`ifdef JK_TO_T_STATS_EN
         if (i >= 3 && q_rise === 1'b1) rises++;
`endif
      end
`ifdef JK_TO_T_STATS_EN
      checks++;
      if (toggle_cnt !== 8'd2 || rises != 1) begin
         errors++;
         $display("FAIL preset_stats: cnt=%0d rises=%0d, required cnt=2 rises=1", toggle_cnt, rises);
      end
`endif
   endtask

   task automatic test_both_and_wrap();
      obs_t e;
      int   n = (1 << CNT_W) + 1;
      apply(1'b0, 1'b1, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (observe() !== e) begin
         errors++;
         $display("FAIL both_setup: got %b, required %b", observe(), e);
      end
      apply(1'b0, 1'b0, 1'b0, 1'b1);
      e = sb.pop_front();
      checks++;
      if ({Q, Qbar} !== 2'b01 || observe() !== e) begin
         errors++;
         $display("FAIL both_low: got %b, required %b", observe(), e);
      end
      for (int i = 0; i < n; i++) begin
         apply(1'b0, 1'b1, 1'b1, 1'b1);
         e = sb.pop_front();
         checks++;
         if (observe() !== e) begin
            errors++;
            $display("FAIL wrap[%0d]: got %b, required %b", i, observe(), e);
         end
      end
`ifdef JK_TO_T_STATS_EN
      checks++;
      if (toggle_cnt !== 8'd1) begin
         errors++;
         $display("FAIL wrap_cnt: got %0d, required 1", toggle_cnt);
      end
`endif
   endtask

   task automatic test_reset_wins();
      obs_t e;
      for (int i = 0; i < 3; i++) begin
         case (i)
            0:       apply(1'b0, 1'b1, 1'b0, 1'b0);
            1:       apply(1'b1, 1'b1, 1'b0, 1'b1);
            default: apply(1'b0, 1'b1, 1'b1, 1'b0);
         endcase
         e = sb.pop_front();
         checks++;
         if (observe() !== e) begin
            errors++;
            $display("FAIL reset_wins[%0d]: got %b, required %b", i, observe(), e);
         end
         if (i == 1) begin
            checks++;
            if ({Q, Qbar} !== 2'b01) begin
               errors++;
               $display("FAIL reset_wins_q: got %b, required 01", {Q, Qbar});
            end
         end
      end
   endtask

   task automatic test_glitch();
      obs_t e;
      for (int i = 0; i < 2; i++) begin
         // pulses confined between edges must not be seen
         #2 T = 1'b1; clr_bar = 1'b0; pre_bar = 1'b0;
         #2 T = 1'b0; clr_bar = 1'b1; pre_bar = 1'b1;
         apply(1'b0, 1'b1, 1'b1, 1'b0);
         e = sb.pop_front();
         checks++;
         if (observe() !== e || Q !== 1'b0) begin
            errors++;
            $display("FAIL glitch[%0d]: got %b, required %b", i, observe(), e);
         end
      end
   endtask

   initial begin
      rst = 1'b1; clr_bar = 1'b1; pre_bar = 1'b1; T = 1'b0;
      m_q = 1'bx; m_cnt = 'x;
      #1;
      test_reset();
      test_clear_toggle();
      test_hold();
      test_preset();
      test_both_and_wrap();
      test_reset_wins();
      test_glitch();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
